// File: rtl/iicmb_wb_sequencer.sv
// Command sequencer for the iicmb_m_wb I2C controller: turns single-byte transfer
// requests into CSR/DPR/CMDR Wishbone sequences. Define IICMB_SEQ_POLL_EN to poll CMDR instead of using irq_i.
module iicmb_wb_sequencer #(
  parameter int WB_ADDR_WIDTH  = 2,
  parameter int WB_DATA_WIDTH  = 8,
  parameter int I2C_ADDR_WIDTH = 7,
  parameter int BUS_ID_WIDTH   = 4,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rw,
  input  logic [BUS_ID_WIDTH-1:0]   req_bus_id,
  input  logic [I2C_ADDR_WIDTH-1:0] req_addr,
  input  logic [WB_DATA_WIDTH-1:0]  req_data,
  output logic                      rsp_valid,
  output logic                      rsp_nak,
  output logic                      rsp_err,
  output logic [WB_DATA_WIDTH-1:0]  rsp_data,
  output logic                      cyc_o,
  output logic                      stb_o,
  output logic                      we_o,
  output logic [WB_ADDR_WIDTH-1:0]  adr_o,
  output logic [WB_DATA_WIDTH-1:0]  dat_o,
  input  logic [WB_DATA_WIDTH-1:0]  dat_i,
  input  logic                      ack_i,
  input  logic                      irq_i
);
  localparam logic [4:0] S_IDLE     = 5'd0,  S_INIT     = 5'd1,  S_BUS_DPR  = 5'd2,
                         S_BUS_CMD  = 5'd3,  S_BUS_WAIT = 5'd4,  S_STA_CMD  = 5'd5,
                         S_STA_WAIT = 5'd6,  S_ADR_DPR  = 5'd7,  S_ADR_CMD  = 5'd8,
                         S_ADR_WAIT = 5'd9,  S_DAT_DPR  = 5'd10, S_DAT_CMD  = 5'd11,
                         S_DAT_WAIT = 5'd12, S_RD_DPR   = 5'd13, S_STO_CMD  = 5'd14,
                         S_STO_WAIT = 5'd15, S_RESP     = 5'd16;

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
  localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
  localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);
`ifdef IICMB_SEQ_POLL_EN
  localparam logic [7:0] CSR_INIT = 8'h80;
`else
  localparam logic [7:0] CSR_INIT = 8'hC0;
`endif

  logic [4:0]                state, nxt;
  logic                      csr_done, rw_q;
  logic [BUS_ID_WIDTH-1:0]   bus_q;
  logic [I2C_ADDR_WIDTH-1:0] addr_q;
  logic [WB_DATA_WIDTH-1:0]  data_q;
  logic [TW-1:0]             tmo_cnt;
  logic                      is_wait, wait_go, tmo_hit, acc_we;
  logic [WB_ADDR_WIDTH-1:0]  acc_adr;
  logic [WB_DATA_WIDTH-1:0]  acc_dat;

  assign req_ready = (state == S_IDLE) && csr_done;
  assign rsp_valid = (state == S_RESP);
  assign is_wait   = state inside {S_BUS_WAIT, S_STA_WAIT, S_ADR_WAIT, S_DAT_WAIT, S_STO_WAIT};
  assign tmo_hit   = (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
`ifdef IICMB_SEQ_POLL_EN
  assign wait_go   = 1'b1;
`else
  assign wait_go   = irq_i;
`endif

  // Access issued by each step and the step that follows a clean completion.
  always_comb begin
    acc_adr = A_CMDR;
    acc_we  = 1'b1;
    acc_dat = '0;
    nxt     = state;
    case (state)
      S_INIT:     begin acc_adr = A_CSR; acc_dat = WB_DATA_WIDTH'(CSR_INIT); nxt = S_IDLE; end
      S_BUS_DPR:  begin acc_adr = A_DPR; acc_dat = WB_DATA_WIDTH'(bus_q); nxt = S_BUS_CMD; end
      S_BUS_CMD:  begin acc_dat = WB_DATA_WIDTH'(8'h06); nxt = S_BUS_WAIT; end
      S_BUS_WAIT: begin acc_we = 1'b0; nxt = S_STA_CMD; end
      S_STA_CMD:  begin acc_dat = WB_DATA_WIDTH'(8'h04); nxt = S_STA_WAIT; end
      S_STA_WAIT: begin acc_we = 1'b0; nxt = S_ADR_DPR; end
      S_ADR_DPR:  begin acc_adr = A_DPR; acc_dat = WB_DATA_WIDTH'({addr_q, rw_q}); nxt = S_ADR_CMD; end
      S_ADR_CMD:  begin acc_dat = WB_DATA_WIDTH'(8'h01); nxt = S_ADR_WAIT; end
      S_ADR_WAIT: begin acc_we = 1'b0; nxt = rw_q ? S_DAT_CMD : S_DAT_DPR; end
      S_DAT_DPR:  begin acc_adr = A_DPR; acc_dat = data_q; nxt = S_DAT_CMD; end
      S_DAT_CMD:  begin acc_dat = WB_DATA_WIDTH'(rw_q ? 8'h03 : 8'h01); nxt = S_DAT_WAIT; end
      S_DAT_WAIT: begin acc_we = 1'b0; nxt = rw_q ? S_RD_DPR : S_STO_CMD; end
      S_RD_DPR:   begin acc_adr = A_DPR; acc_we = 1'b0; nxt = S_STO_CMD; end
      S_STO_CMD:  begin acc_dat = WB_DATA_WIDTH'(8'h05); nxt = S_STO_WAIT; end
      S_STO_WAIT: begin acc_we = 1'b0; nxt = S_RESP; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state    <= S_INIT;
      csr_done <= 1'b0;
      cyc_o    <= 1'b0;
      stb_o    <= 1'b0;
      we_o     <= 1'b0;
      adr_o    <= '0;
      dat_o    <= '0;
      rw_q     <= 1'b0;
      bus_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      tmo_cnt  <= '0;
      rsp_nak  <= 1'b0;
      rsp_err  <= 1'b0;
      rsp_data <= '0;
    end else begin
      // Zero outside WAIT so every WAIT starts a fresh count.
      tmo_cnt <= is_wait ? tmo_cnt + TW'(1) : '0;
      case (state)
        S_IDLE:
          if (req_valid && req_ready) begin
            rw_q   <= req_rw;
            bus_q  <= req_bus_id;
            addr_q <= req_addr;
            data_q <= req_data;
            state  <= S_BUS_DPR;
          end
        S_RESP: begin
          rsp_nak  <= 1'b0;
          rsp_err  <= 1'b0;
          rsp_data <= '0;
          state    <= S_IDLE;
        end
        default:
          if (is_wait && tmo_hit && !(cyc_o && ack_i)) begin
            cyc_o   <= 1'b0;
            stb_o   <= 1'b0;
            we_o    <= 1'b0;
            rsp_err <= 1'b1;
            state   <= S_RESP;
          end else if (cyc_o) begin
            if (ack_i) begin
              cyc_o <= 1'b0;
              stb_o <= 1'b0;
              we_o  <= 1'b0;
              adr_o <= '0;
              dat_o <= '0;
              if (is_wait) begin
                // CMDR status: 7 DON, 6 NAK, 5 AL, 4 ERR; no bit set means keep waiting.
                if (dat_i[5] || dat_i[4]) begin
                  rsp_err <= 1'b1;
                  state   <= S_RESP;
                end else if (dat_i[6] && (state == S_ADR_WAIT || (state == S_DAT_WAIT && !rw_q))) begin
                  rsp_nak <= 1'b1;
                  state   <= S_STO_CMD;
                end else if (dat_i[7]) begin
                  state <= nxt;
                end
              end else begin
                if (state == S_RD_DPR) rsp_data <= dat_i;
                if (state == S_INIT) csr_done <= 1'b1;
                state <= nxt;
              end
            end
          end else if (!is_wait || wait_go) begin
            cyc_o <= 1'b1;
            stb_o <= 1'b1;
            we_o  <= acc_we;
            adr_o <= acc_adr;
            dat_o <= acc_we ? acc_dat : '0;
          end
      endcase
    end
  end
endmodule
